// File: rtl/clk_div_ctrl.sv
// Runtime-programmable glitch-free clock divider: clk_out half-period = N clk cycles, N loaded over valid/ready.
// Ratio changes and stops wait for a phase boundary, so clk_out never shows a truncated phase.
module clk_div_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             cfg_en,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] PENDING = 2'd2;
    localparam logic [1:0] STOP    = 2'd3;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_pend;
    logic             track;

    logic accept;
    logic div_zero;
    logic load;
    logic boundary;

    always_comb begin
        cfg_ready = (state == IDLE) || (state == RUN);
        accept    = cfg_valid && cfg_ready;
        div_zero  = (cfg_div == '0);
        load      = accept && !div_zero;
        // Comparing against div_act-1 keeps N = 2^WIDTH-1 legal without widening cnt.
        boundary  = (state != IDLE) && (cnt == div_act - ONE);
        busy      = (state != IDLE);
        clk_out   = ~track;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            div_act  <= WIDTH'(DEFAULT_DIV);
            div_pend <= WIDTH'(DEFAULT_DIV);
            track    <= 1'b0;
            tick     <= 1'b0;
            err      <= 1'b0;
        end else begin
            tick <= boundary;
            err  <= accept && div_zero;
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    track <= 1'b0;
                    if (load) begin
                        div_act <= cfg_div;
                        if (cfg_en) begin
                            state <= RUN;
                        end
                    end
                end
                RUN, PENDING, STOP: begin
                    if (boundary) begin
                        cnt   <= '0;
                        track <= ~track;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                    // A boundary on the accept edge uses the old ratio; a new one waits for the next boundary.
                    if (state == RUN && load) begin
                        if (cfg_en) begin
                            div_pend <= cfg_div;
                            state    <= PENDING;
                        end else begin
                            state <= STOP;
                        end
                    end else if (state == PENDING && boundary) begin
                        div_act <= div_pend;
                        state   <= RUN;
                    end else if (state == STOP && boundary && track) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: expected clk_out edges are queued when a config is accepted,
// and a monitor pops and checks them (with tick alignment) as the divided clock toggles.
module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_div = 8'd0;
    logic       cfg_en = 1'b0;
    logic       clk_out;
    logic       tick;
    logic       busy;
    logic       err;

    clk_div_ctrl #(.WIDTH(8), .DEFAULT_DIV(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic lvl;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;
    logic prev_clk = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Edge monitor: every clk_out change must match the queue head; tick must mark exactly those cycles.
    always @(posedge clk) begin
        logic changed;
        ev_t  e;
        #1;
        changed = (clk_out !== prev_clk);
        if (mon_en) begin
            n_chk++;
            if (tick !== changed) begin
                n_fail++;
                $display("FAIL tick_align cyc=%0d tick=%b required=%b", cyc, tick, changed);
            end
            if (changed) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_edge cyc=%0d clk_out=%b required no edge", cyc, clk_out);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc !== cyc || e.lvl !== clk_out) begin
                        n_fail++;
                        $display("FAIL edge cyc=%0d lvl=%b required cyc=%0d lvl=%b", cyc, clk_out, e.cyc, e.lvl);
                    end
                end
            end
        end
        prev_clk = clk_out;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic push_ev(input int c, input logic l);
        ev_t e;
        e.cyc = c;
        e.lvl = l;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        cfg_valid = 1'b0;
        reset     = 1'b1;
        step();
        step();
        exp_q.delete();
        reset = 1'b0;
        step();
        mon_en = 1'b1;
    endtask

    task automatic send_cfg(input logic [7:0] d, input logic en, output int acc);
        logic r;
        cfg_div   = d;
        cfg_en    = en;
        cfg_valid = 1'b1;
        acc       = -1;
        for (int i = 0; i < 2000; i++) begin
            r = cfg_ready;
            step();
            if (r) begin
                acc = cyc;
                break;
            end
        end
        cfg_valid = 1'b0;
        if (acc < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL cfg_timeout div=%0d en=%b not accepted within 2000 cycles", d, en);
        end
    endtask

    task automatic test_reset();
        int k;
        #3;
        n_chk++;
        if ({clk_out, cfg_ready, busy, tick, err} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_init {clk_out,rdy,busy,tick,err}=%b required 11000",
                     {clk_out, cfg_ready, busy, tick, err});
        end
        do_reset();
        mon_en = 1'b0;
        send_cfg(8'd3, 1'b1, k);
        for (int i = 0; i < 20 && clk_out !== 1'b0; i++) step();
        n_chk++;
        if (clk_out !== 1'b0 || tick !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prep clk_out=%b tick=%b required 0 1", clk_out, tick);
        end
        #3;
        reset = 1'b1;
        #1;
        n_chk++;
        if ({clk_out, cfg_ready, busy, tick, err} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_async {clk_out,rdy,busy,tick,err}=%b required 11000",
                     {clk_out, cfg_ready, busy, tick, err});
        end
    endtask

    task automatic test_div4();
        int k;
        do_reset();
        send_cfg(8'd2, 1'b1, k);
        for (int i = 1; i <= 6; i++) push_ev(k + 2 * i, (i % 2 == 0));
        run_until(k + 12);
        n_chk++;
        if (exp_q.size() != 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL div4_done pending=%0d busy=%b required 0 1", exp_q.size(), busy);
        end
    endtask

    task automatic test_ratio_change();
        int k;
        int a;
        do_reset();
        send_cfg(8'd2, 1'b1, k);
        push_ev(k + 2, 1'b0);
        push_ev(k + 4, 1'b1);
        push_ev(k + 6, 1'b0);
        push_ev(k + 11, 1'b1);
        push_ev(k + 16, 1'b0);
        push_ev(k + 21, 1'b1);
        run_until(k + 4);
        send_cfg(8'd5, 1'b1, a);
        n_chk++;
        if (a !== k + 5 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ratio_accept acc=%0d rdy=%b required acc=%0d rdy=0", a, cfg_ready, k + 5);
        end
        step();
        n_chk++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ratio_ready_back rdy=%b required 1", cfg_ready);
        end
        run_until(k + 21);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ratio_done pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_stop();
        int k;
        int a;
        do_reset();
        send_cfg(8'd3, 1'b1, k);
        push_ev(k + 3, 1'b0);
        push_ev(k + 6, 1'b1);
        run_until(k + 3);
        send_cfg(8'd3, 1'b0, a);
        n_chk++;
        if (a !== k + 4 || busy !== 1'b1 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_accept acc=%0d busy=%b rdy=%b required %0d 1 0", a, busy, cfg_ready, k + 4);
        end
        run_until(k + 5);
        n_chk++;
        if (busy !== 1'b1 || clk_out !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_low busy=%b clk_out=%b required 1 0", busy, clk_out);
        end
        step();
        n_chk++;
        if (busy !== 1'b0 || clk_out !== 1'b1 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_idle busy=%b clk_out=%b rdy=%b required 0 1 1", busy, clk_out, cfg_ready);
        end
        run_until(k + 16);
        n_chk++;
        if (dut.cnt !== 8'd0 || clk_out !== 1'b1 || busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stop_hold cnt=%0d clk_out=%b busy=%b pending=%0d required 0 1 0 0",
                     dut.cnt, clk_out, busy, exp_q.size());
        end
    endtask

    task automatic test_zero_div();
        int z;
        int k;
        do_reset();
        send_cfg(8'd0, 1'b1, z);
        n_chk++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_idle err=%b busy=%b required 1 0", err, busy);
        end
        step();
        n_chk++;
        if (err !== 1'b0 || busy !== 1'b0 || clk_out !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_idle_after err=%b busy=%b clk_out=%b required 0 0 1", err, busy, clk_out);
        end
        send_cfg(8'd3, 1'b1, k);
        for (int i = 1; i <= 6; i++) push_ev(k + 3 * i, (i % 2 == 0));
        run_until(k + 4);
        send_cfg(8'd0, 1'b1, z);
        n_chk++;
        if (z !== k + 5 || err !== 1'b1 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_run acc=%0d err=%b rdy=%b required %0d 1 1", z, err, cfg_ready, k + 5);
        end
        step();
        send_cfg(8'd0, 1'b0, z);
        n_chk++;
        if (z !== k + 7 || err !== 1'b1 || cfg_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_stop acc=%0d err=%b rdy=%b busy=%b required %0d 1 1 1",
                     z, err, cfg_ready, busy, k + 7);
        end
        step();
        n_chk++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_pulse err=%b required 0", err);
        end
        run_until(k + 18);
        n_chk++;
        if (exp_q.size() != 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_period pending=%0d busy=%b required 0 1", exp_q.size(), busy);
        end
    endtask

    task automatic test_max_backpressure();
        int k;
        int a;
        int b;
        do_reset();
        send_cfg(8'd255, 1'b1, k);
        push_ev(k + 255, 1'b0);
        push_ev(k + 510, 1'b1);
        push_ev(k + 514, 1'b0);
        push_ev(k + 521, 1'b1);
        push_ev(k + 528, 1'b0);
        run_until(k + 300);
        send_cfg(8'd4, 1'b1, a);
        n_chk++;
        if (a !== k + 301 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL max_pend acc=%0d rdy=%b required %0d 0", a, cfg_ready, k + 301);
        end
        send_cfg(8'd7, 1'b1, b);
        n_chk++;
        if (b !== k + 511) begin
            n_fail++;
            $display("FAIL backpressure acc=%0d required %0d", b, k + 511);
        end
        run_until(k + 528);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL max_done pending=%0d required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_div4();
        test_ratio_change();
        test_stop();
        test_zero_div();
        test_max_backpressure();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Runtime-programmable, glitch-free clock divider controller. Generates a divided clock `clk_out` from `clk` with a half-period of N input cycles, where N is loaded over a valid/ready configuration port. Ratio changes and stop requests are deferred to safe phase boundaries so `clk_out` never shows a truncated phase. It sits between the configuration/register logic and the downstream blocks that consume divided clocks; fixed divide-by-4 use is N=2.

## Interface
- `WIDTH`, default 8: width of the half-period count N; legal N is 1..2^WIDTH-1.
- `DEFAULT_DIV`, default 2: value of the active divisor after reset.
- `clk`  input  1: input clock, rising-edge.
- `reset`  input  1: asynchronous, active-high.
- `cfg_valid`  input  1: configuration request.
- `cfg_ready`  output  1: controller can accept a configuration.
- `cfg_div`  input  WIDTH: requested half-period N.
- `cfg_en`  input  1: 1 = run with `cfg_div`; 0 = stop.
- `clk_out`  output  1: divided clock; idle level is 1.
- `tick`  output  1: one-cycle pulse marking each `clk_out` edge.
- `busy`  output  1: controller is not in IDLE.
- `err`  output  1: one-cycle pulse when a config with `cfg_div`==0 is rejected.

## Operation
- **Internal state:**
  - `cnt[WIDTH-1:0]`, `div_act`, `div_pend`, `track`.
  - `clk_out` = ~`track`.
  - FSM states: IDLE, RUN, PENDING, STOP.
- **Reset values:** state IDLE, `cnt`=0, `div_act`=DEFAULT_DIV, `track`=0 (so `clk_out`=1), `cfg_ready`=1, `tick`=0, `busy`=0, `err`=0.
- **Handshake:**
  - A transfer happens on a rising edge with `cfg_valid` & `cfg_ready`.
  - `cfg_ready`=1 in IDLE and RUN, 0 in PENDING and STOP.
  - The requester holds `cfg_valid`/`cfg_div`/`cfg_en` stable until accepted.
- **Zero divisor:** an accepted transfer with `cfg_div`==0 is dropped. `err`=1 for the next cycle; state and registers are unchanged, regardless of `cfg_en`.
- **IDLE:**
  - `cnt` is held at 0 and `track` at 0.
  - Accept with `cfg_en`=1: `div_act`<=`cfg_div`, `cnt`<=0, go to RUN.
  - Accept with `cfg_en`=0: `div_act`<=`cfg_div`, stay in IDLE.
- **RUN, PENDING and STOP all count:**
  - Each cycle, `cnt`<=`cnt`+1.
  - When `cnt`==`div_act`-1: `cnt`<=0, `track` toggles, and `tick` is high for the following cycle. This is a "boundary".
  - The width rule is compare-to-(`div_act`-1), so `cnt` never wraps past `div_act`-1. N=2^WIDTH-1 is legal.
- **RUN:**
  - Accept with `cfg_en`=1: `div_pend`<=`cfg_div`, go to PENDING. This applies even if the value equals `div_act`.
  - Accept with `cfg_en`=0: go to STOP.
- **PENDING:** at the next boundary, `div_act`<=`div_pend` and go to RUN. The half-period that just ended used the old N; the next one uses the new N.
- **STOP:**
  - At a boundary where `track` goes 1->0 (`clk_out` rises to 1): go to IDLE, `cnt`<=0.
  - A boundary where `track` goes 0->1 continues counting.
- **Status:** `busy` = (state != IDLE).

## Timing
- **Start latency:** for a config accepted at edge k (IDLE->RUN), `clk_out` falls at edge k+N, rises at k+2N, and so on. The period is 2N cycles with 50% duty.
- **Tick alignment:** `tick` is high during exactly the cycle following each `clk_out` transition edge.
- **Stop latency:** after a stop is accepted, IDLE is reached at the first rising edge of `clk_out`. Worst case is 2N cycles.
  - If the stop is accepted while `clk_out`=0, IDLE is reached at the end of the current low phase.
- **Ratio change latency:** the ratio change takes effect at the first boundary after acceptance, at most N_old cycles later.
- **Simultaneous events:**
  - `reset` dominates everything.
  - A boundary on the acceptance edge is evaluated with the pre-accept state. The new config waits for the next boundary.
- **Reset mid-operation:** all outputs return to their reset values immediately and asynchronously; `clk_out` goes to 1 without waiting for a boundary.

## Test plan
- **Reset values:** assert `reset` mid-run with `clk_out`=0. Required: `clk_out`=1, `cfg_ready`=1, `busy`=0, `tick`=0, `err`=0 immediately, before the next clock edge.
- **Divide-by-4 start:** accept `cfg_div`=2, `cfg_en`=1 at edge 0. Required: `clk_out` falls at edge 2, rises at 4, falls at 6 (period 4), and `tick` pulses every 2 cycles.
- **Ratio change:** while running at N=2, accept N=5 one cycle after a boundary. Required:
  - `cfg_ready`=0 until the next boundary.
  - That boundary closes a 2-cycle phase; subsequent phases are 5 cycles.
  - No phase is shorter than 2 cycles.
- **Stop:** at N=3, accept `cfg_en`=0 during the low phase. Required: `clk_out` completes the low phase, rises, and `busy` drops at that same edge. The counter then stays 0 and `clk_out` stays 1.
- **Zero divisor:** accept `cfg_div`=0 in IDLE and in RUN. Required: `err` is a one-cycle pulse in each case, with no change to the `clk_out` period or to state.
- **Maximum divisor and backpressure:** run N=255 and check 255-cycle phases. Drive `cfg_valid` during PENDING and check it is stalled until `cfg_ready` returns at the boundary, then accepted.
